keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad by driving one column low at a time and sampling the four row lines.
- Outputs a raw key-pressed level and a locked 4-bit key code.
- Sits directly upstream of the button debouncer: key_pressed feeds the debouncer's enable input; key_code is consumed once the debounced level asserts.
- Rows are asynchronous, pulled up and active-low; columns are driven active-low.

---
 rtl/keypad_pkg.sv | 15 +
 rtl/keypad_scanner_if.sv | 10 +
 rtl/keypad_scanner_row_sync.sv | 17 +
 rtl/keypad_scanner.sv | 53 +++++
 tb/tb_keypad_scanner.sv | 118 +++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, key map and helpers for the 4x4 keypad scanner
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  typedef enum logic {SCAN = 1'b0, HOLD = 1'b1} state_t;
  localparam logic [3:0] KEYMAP [NUM_ROWS][NUM_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };
  function automatic logic [1:0] lowest_row(input logic [NUM_ROWS-1:0] r);
    return r[0] ? 2'd0 : r[1] ? 2'd1 : r[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_if: keypad matrix lines plus the press level and key code sent downstream
interface keypad_if;
  import keypad_pkg::*;
  logic [NUM_ROWS-1:0] row_n;
  logic [NUM_COLS-1:0] col_n;
  logic key_pressed;
  logic [3:0] key_code;
  modport master (input row_n, output col_n, output key_pressed, output key_code);
  modport slave (output row_n, input col_n, input key_pressed, input key_code);
endinterface

// File: rtl/keypad_scanner_row_sync.sv
// row_sync: multi-flop synchronizer for the pulled-up keypad rows, resets to idle (all ones)
module row_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [SYNC_STAGES-1:0][3:0] ff;
  // shift raw rows through the synchronizer chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff <= '1;
    else ff <= {ff[SYNC_STAGES-2:0], d};
  end
  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: one-cold column scan of a 4x4 keypad; KEYPAD_MULTIKEY_REJECT_EN rejects multi-row presses
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 48000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  keypad_if.master bus
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt;
  logic [1:0] col_idx;
  logic [NUM_ROWS-1:0] row_q, row_s;
  logic tick, hit;
  state_t state;
  row_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .reset(reset), .d(bus.row_n), .q(row_q));
  assign row_s = ~row_q;
  assign tick = cnt == CW'(SCAN_DIV - 1);
  assign bus.col_n = ~(4'b0001 << col_idx);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
  assign hit = (|row_s) && ((row_s & (row_s - 4'd1)) == 4'd0);
`else
  assign hit = |row_s;
`endif
  // dwell counter: one tick at the end of each column dwell
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  end
  // scan/hold state machine, rows only judged on tick once lines have settled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SCAN;
      col_idx <= '0;
      bus.key_pressed <= 1'b0;
      bus.key_code <= 4'h0;
    end else if (tick) begin
      if (state == SCAN) begin
        if (hit) begin
          state <= HOLD;
          bus.key_pressed <= 1'b1;
          bus.key_code <= KEYMAP[lowest_row(row_s)][col_idx];
        end else col_idx <= col_idx + 2'd1;
      end else if (row_s == '0) begin
        state <= SCAN;
        bus.key_pressed <= 1'b0;
        col_idx <= col_idx + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad presses with a scoreboard of expected key codes
module tb_keypad_scanner;
  logic clk, reset;
  logic [3:0][3:0] pressed;
  logic [3:0] row_n_m;
  logic [3:0] exp_q[$];
  logic [3:0] seen;
  int n_checks, n_fail, n;
  keypad_if bus ();
  keypad_scanner #(.SCAN_DIV(4), .SYNC_STAGES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // keypad model: a pressed key shorts its row low while its column is driven low
  always_comb for (int r = 0; r < 4; r++) row_n_m[r] = ~|(pressed[r] & ~bus.col_n);
  assign bus.row_n = row_n_m;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_kp(input logic lvl, input int bound, output int cyc);
    cyc = 0;
    while (bus.key_pressed !== lvl && cyc < bound + 5) begin
      @(negedge clk);
      cyc++;
    end
    check("kp_wait", 8'(bus.key_pressed), 8'(lvl));
    check("kp_latency", 8'(cyc <= bound), 8'd1);
  endtask

  task automatic pop_check(input string tag);
    logic [3:0] e;
    e = exp_q.pop_front();
    check(tag, 8'(bus.key_code), 8'(e));
  endtask

  initial begin
    logic [3:0] steps [4];
    steps = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    clk = 0; reset = 1; pressed = '0; n_checks = 0; n_fail = 0;
    repeat (2) @(negedge clk);
    check("rst_col", 8'(bus.col_n), 8'h0E);
    check("rst_kp", 8'(bus.key_pressed), 8'd0);
    check("rst_code", 8'(bus.key_code), 8'h0);
    reset = 0;
    repeat (3) @(negedge clk);
    check("idle_dwell", 8'(bus.col_n), 8'h0E);
    @(negedge clk);
    check("idle_step0", 8'(bus.col_n), 8'(steps[0]));
    for (int k = 1; k < 4; k++) begin
      repeat (4) @(negedge clk);
      check("idle_step", 8'(bus.col_n), 8'(steps[k]));
    end
    check("idle_kp", 8'(bus.key_pressed), 8'd0);
    pressed[1][1] = 1'b1;
    exp_q.push_back(4'h5);
    wait_kp(1'b1, 19, n);
    pop_check("code_5");
    check("col_5", 8'(bus.col_n), 8'h0D);
    repeat (8) @(negedge clk);
    check("hold_kp_5", 8'(bus.key_pressed), 8'd1);
    check("hold_col_5", 8'(bus.col_n), 8'h0D);
    pressed = '0;
    wait_kp(1'b0, 8, n);
    check("rel_code_5", 8'(bus.key_code), 8'h5);
    check("rel_col_5", 8'(bus.col_n), 8'h0B);
    pressed[3][3] = 1'b1;
    exp_q.push_back(4'hD);
    wait_kp(1'b1, 19, n);
    pop_check("code_D");
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("hold_kp_D", 8'(bus.key_pressed), 8'd1);
      check("hold_col_D", 8'(bus.col_n), 8'h07);
    end
    check("hold_code_D", 8'(bus.key_code), 8'hD);
    pressed = '0;
    wait_kp(1'b0, 8, n);
    pressed[0][0] = 1'b1;
    pressed[1][0] = 1'b1;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    seen = '0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      check("multi_kp", 8'(bus.key_pressed), 8'd0);
      seen |= ~bus.col_n;
    end
    check("multi_cycle", 8'(seen), 8'h0F);
    pressed = '0;
    repeat (4) @(negedge clk);
`else
    exp_q.push_back(4'h1);
    wait_kp(1'b1, 19, n);
    pop_check("code_multi");
    check("col_multi", 8'(bus.col_n), 8'h0E);
    pressed = '0;
    wait_kp(1'b0, 8, n);
`endif
    pressed[1][1] = 1'b1;
    exp_q.push_back(4'h5);
    wait_kp(1'b1, 19, n);
    pop_check("code_5b");
    #2 reset = 1;
    #1;
    check("arst_col", 8'(bus.col_n), 8'h0E);
    check("arst_kp", 8'(bus.key_pressed), 8'd0);
    check("arst_code", 8'(bus.key_code), 8'h0);
    pressed = '0;
    @(negedge clk);
    reset = 0;
    check("sb_empty", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
